// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the command control unit, with paced single-cycle pops.
// Optional build macro RX_CMD_FILTER_EN: store only the command bytes 'r' (8'h72) and 's' (8'h73).
module uart_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 3,
   parameter int POP_GAP    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_done,
   input  logic [DATA_W-1:0]     rx_data,
   input  logic                  ovf_clr,
   output logic                  Rx_trigger,
   output logic [DATA_W-1:0]     Rx_fifo_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int GAP_W = (POP_GAP > 2) ? $clog2(POP_GAP) : 1;

   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1'b1);
   localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(1'b0);
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1'b1);
   localparam logic [GAP_W-1:0]      GAP_ZERO = GAP_W'(1'b0);
   localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(POP_GAP - 2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    trig_q, trig_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic [DATA_W-1:0]       mem [DEPTH];

   logic                    full_s, empty_s;
   logic                    byte_ok_s, push_req_s, push_s, pop_s, drop_s;

`ifdef RX_CMD_FILTER_EN
   function automatic logic is_cmd_byte(input logic [DATA_W-1:0] b);
      return (b == DATA_W'(8'h72)) || (b == DATA_W'(8'h73));
   endfunction

   assign byte_ok_s = is_cmd_byte(rx_data);
`else
   assign byte_ok_s = 1'b1;
`endif

   assign full_s     = (count_q == CNT_FULL);
   assign empty_s    = (count_q == CNT_ZERO);
   // Pops only look at the registered count, so a byte can never fall through in its push cycle.
   assign pop_s      = (state_q == ST_IDLE) && !empty_s;
   assign push_req_s = rx_done && byte_ok_s;
   assign push_s     = push_req_s && (!full_s || pop_s);
   assign drop_s     = push_req_s && !push_s;

   // Occupancy, write pointer and sticky overflow next-state.
   always_comb begin
      wptr_d  = wptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (push_s) begin
         wptr_d = wptr_q + PTR_ONE;
      end else begin
         wptr_d = wptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Pop engine: IDLE pops, POP holds the trigger, WAIT paces the next pop.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      trig_d  = 1'b0;
      data_d  = data_q;
      rptr_d  = rptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               state_d = ST_POP;
               trig_d  = 1'b1;
               data_d  = mem[rptr_q];
               rptr_d  = rptr_q + PTR_ONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_POP: begin
            if (POP_GAP > 2) begin
               state_d = ST_WAIT;
               gap_d   = GAP_LOAD;
            end else begin
               state_d = ST_IDLE;
               gap_d   = GAP_ZERO;
            end
         end
         ST_WAIT: begin
            // The WAIT entry cycle already counts, so leave as the count reaches zero.
            if (gap_q <= GAP_ONE) begin
               state_d = ST_IDLE;
               gap_d   = GAP_ZERO;
            end else begin
               state_d = ST_WAIT;
               gap_d   = gap_q - GAP_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gap_d   = GAP_ZERO;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         gap_q   <= GAP_ZERO;
         wptr_q  <= {DEPTH_LOG2{1'b0}};
         rptr_q  <= {DEPTH_LOG2{1'b0}};
         count_q <= CNT_ZERO;
         ovf_q   <= 1'b0;
         trig_q  <= 1'b0;
         data_q  <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         trig_q  <= trig_d;
         data_q  <= data_d;
      end
   end

   // Storage array; a pop on a full-FIFO push edge still reads the old entry.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem[wptr_q] <= rx_data;
      end
   end

   assign Rx_trigger   = trig_q;
   assign Rx_fifo_data = data_q;
   assign full         = full_s;
   assign empty        = empty_s;
   assign count        = count_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int POP_GAP = 3;
   localparam int DEPTH   = 8;

   logic       clk;
   logic       rst;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       ovf_clr;
   logic       Rx_trigger;
   logic [7:0] Rx_fifo_data;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       overflow;

   uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(3), .POP_GAP(POP_GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_done      (rx_done),
      .rx_data      (rx_data),
      .ovf_clr      (ovf_clr),
      .Rx_trigger   (Rx_trigger),
      .Rx_fifo_data (Rx_fifo_data),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: queue contents, time of last pop, expected outputs
   logic [7:0] q[$];
   int         cyc;
   int         last_pop;
   logic       exp_trig;
   logic [7:0] exp_data;
   logic       exp_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic accepts(input logic [7:0] d);
`ifdef RX_CMD_FILTER_EN
      return (d == 8'h72) || (d == 8'h73);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      cyc      = 0;
      last_pop = -1000;
      exp_trig = 1'b0;
      exp_data = 8'h00;
      exp_ovf  = 1'b0;
   endtask

   task automatic model_edge(input logic rd, input logic [7:0] d, input logic clr);
      logic do_pop;
      logic was_full;
      do_pop   = (q.size() > 0) && (cyc - last_pop >= POP_GAP);
      was_full = (q.size() == DEPTH);
      exp_trig = 1'b0;
      if (do_pop) begin
         exp_data = q.pop_front();
         exp_trig = 1'b1;
         last_pop = cyc;
      end
      if (rd && accepts(d) && was_full && !do_pop) begin
         exp_ovf = 1'b1;
      end else begin
         if (rd && accepts(d)) q.push_back(d);
         if (clr) exp_ovf = 1'b0;
      end
      cyc++;
   endtask

   task automatic check_all();
      chk("trigger",  {31'd0, Rx_trigger}, {31'd0, exp_trig});
      chk("data",     {24'd0, Rx_fifo_data}, {24'd0, exp_data});
      chk("count",    {28'd0, count}, q.size());
      chk("empty",    {31'd0, empty}, {31'd0, (q.size() == 0)});
      chk("full",     {31'd0, full}, {31'd0, (q.size() == DEPTH)});
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   task automatic step(input logic rd, input logic [7:0] d, input logic clr);
      @(negedge clk);
      rx_done = rd;
      rx_data = d;
      ovf_clr = clr;
      @(posedge clk);
      model_edge(rd, d, clr);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_trig"},  {31'd0, Rx_trigger}, 32'd0);
      chk({tag, "_data"},  {24'd0, Rx_fifo_data}, 32'd0);
      chk({tag, "_count"}, {28'd0, count}, 32'd0);
      chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
      chk({tag, "_full"},  {31'd0, full}, 32'd0);
      chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
   endtask

   // Assert reset mid-cycle (asynchronously), hold it over an edge, release at a falling edge.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst     = 1'b0;
      rx_done = 1'b0;
      ovf_clr = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] d;
      int         dens;
      rst     = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      ovf_clr = 1'b0;
      model_reset();
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // single byte pushed at edge 10 after reset release
      idle(9);
      step(1'b1, 8'h72, 1'b0);
      idle(6);

      // short burst
      step(1'b1, 8'h72, 1'b0);
      step(1'b1, 8'h73, 1'b0);
      step(1'b1, 8'h41, 1'b0);
      idle(10);

      // back-to-back bytes beyond capacity, then clear the sticky flag
      for (int i = 0; i < 14; i++) step(1'b1, i[7:0], 1'b0);
      chk("ovf_set", {31'd0, overflow}, {31'd0, accepts(8'h00)});
      idle(30);
      step(1'b0, 8'h00, 1'b1);
      chk("ovf_clr", {31'd0, overflow}, 32'd0);

      // long stream keeps the FIFO full across pop edges and wraps pointers
      for (int i = 0; i < 20; i++) step(1'b1, 8'h80 + i[7:0], 1'b0);
      idle(30);

      // filter-relevant mix
      step(1'b1, 8'h41, 1'b0);
      step(1'b1, 8'h72, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h73, 1'b0);
      idle(12);

      // reset with five bytes stored, then no trigger after release
      for (int i = 0; i < 7; i++) step(1'b1, 8'h72 + i[7:0], 1'b0);
      async_reset();
      idle(10);

      // randomized traffic with varying density
      for (int blk = 0; blk < 40; blk++) begin
         dens = $urandom_range(0, 100);
         for (int i = 0; i < 50; i++) begin
            d = $urandom_range(0, 255);
            if ($urandom_range(0, 2) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h72 : 8'h73;
            step(($urandom_range(0, 99) < dens), d, ($urandom_range(0, 19) == 0));
         end
         if (blk == 25) begin
            async_reset();
            idle(5);
         end
      end
      idle(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
